// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and helpers shared by the VGA timing blocks.
package vga_timing_pkg;

    localparam int unsigned DefaultHActive = 640;
    localparam int unsigned DefaultHFp     = 16;
    localparam int unsigned DefaultHSync   = 96;
    localparam int unsigned DefaultHBp     = 48;
    localparam int unsigned DefaultVActive = 480;
    localparam int unsigned DefaultVFp     = 10;
    localparam int unsigned DefaultVSync   = 2;
    localparam int unsigned DefaultVBp     = 33;

    function automatic int unsigned H_TOTAL(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned V_TOTAL(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register; synchronous reset loads every stage with RESET_VAL.
module vga_delay_line #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock25Mhz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = data_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock25Mhz) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: a request stream LEAD cycles ahead for pixel fetch and a
// registered display stream aligned to the returned pixel data.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefaultHActive,
    parameter int unsigned H_FP     = DefaultHFp,
    parameter int unsigned H_SYNC   = DefaultHSync,
    parameter int unsigned H_BP     = DefaultHBp,
    parameter int unsigned V_ACTIVE = DefaultVActive,
    parameter int unsigned V_FP     = DefaultVFp,
    parameter int unsigned V_SYNC   = DefaultVSync,
    parameter int unsigned V_BP     = DefaultVBp,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned LEAD     = 2,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned FC_W     = 16
) (
    input  logic            clock25Mhz,
    input  logic            reset,
    output logic            reqActive,
    output logic [X_W-1:0]  reqX,
    output logic [Y_W-1:0]  reqY,
    output logic            hSync,
    output logic            vSync,
    output logic            isActive,
    output logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  y,
    output logic            lineStart,
    output logic            frameStart,
    output logic [FC_W-1:0] frameCount
);

    localparam int unsigned HTotal     = H_TOTAL(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTotal     = V_TOTAL(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
    localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
    localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
    localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
    localparam int unsigned BundleW    = 5 + X_W + Y_W;

    // Bundle layout: {hSync, vSync, active, x, y, lineStart, frameStart}
    localparam logic [BundleW-1:0] BlankBundle =
        {~H_POL, ~V_POL, 1'b0, {X_W{1'b0}}, {Y_W{1'b0}}, 2'b00};

    logic [X_W-1:0]  hc_q, hc_d;
    logic [Y_W-1:0]  vc_q, vc_d;
    logic [FC_W-1:0] frame_count_q, frame_count_d;
    logic            h_last, v_last;

    logic [31:0]        hc_ext, vc_ext;
    logic               req_hsync, req_vsync, req_line, req_frame;
    logic [BundleW-1:0] req_bundle, disp_bundle;

    always_comb begin
        h_last        = (hc_q == X_W'(HTotal - 1));
        v_last        = (vc_q == Y_W'(VTotal - 1));
        hc_d          = h_last ? '0 : hc_q + 1'b1;
        vc_d          = vc_q;
        frame_count_d = frame_count_q;
        if (h_last) begin
            vc_d = v_last ? '0 : vc_q + 1'b1;
        end
        if (h_last && v_last) begin
            frame_count_d = frame_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock25Mhz) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            frame_count_q <= '0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Compare at 32 bits so a zero-width back porch cannot overflow the coordinate width.
    always_comb begin
        hc_ext     = 32'(hc_q);
        vc_ext     = 32'(vc_q);
        reqActive  = (hc_ext < H_ACTIVE) && (vc_ext < V_ACTIVE);
        reqX       = reqActive ? hc_q : '0;
        reqY       = reqActive ? vc_q : '0;
        req_hsync  = ((hc_ext >= HSyncStart) && (hc_ext < HSyncEnd)) ? H_POL : ~H_POL;
        req_vsync  = ((vc_ext >= VSyncStart) && (vc_ext < VSyncEnd)) ? V_POL : ~V_POL;
        req_line   = (hc_q == '0);
        req_frame  = (hc_q == '0) && (vc_q == '0);
        req_bundle = {req_hsync, req_vsync, reqActive, reqX, reqY, req_line, req_frame};
    end

    vga_delay_line #(
        .WIDTH     (BundleW),
        .DEPTH     (LEAD),
        .RESET_VAL (BlankBundle)
    ) u_disp_delay (
        .clock25Mhz (clock25Mhz),
        .reset      (reset),
        .data_i     (req_bundle),
        .data_o     (disp_bundle)
    );

    always_comb begin
        {hSync, vSync, isActive, x, y, lineStart, frameStart} = disp_bundle;
        frameCount = frame_count_q;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three configurations of vga_timing_gen checked every cycle against a position-based model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, lead, fcw;
    } cfg_t;

    typedef struct {
        int act, x, y, hs, vs, ls, fs;
    } bnd_t;

    localparam cfg_t CfgA = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 16};
    localparam cfg_t CfgB = '{64, 4, 8, 4, 48, 2, 2, 3, 1, 1, 1, 8};
    localparam cfg_t CfgC = '{4, 1, 1, 1, 2, 1, 1, 1, 0, 0, 2, 2};

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int   n_a = 0, n_b = 0, n_c = 0;
    bit   valid_a = 0, valid_b = 0, valid_c = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #20 clk = ~clk;

    logic        ra_a, hs_a, vs_a, ia_a, ls_a, fs_a;
    logic [9:0]  rx_a, ry_a, x_a, y_a;
    logic [15:0] fc_a;
    logic        ra_b, hs_b, vs_b, ia_b, ls_b, fs_b;
    logic [6:0]  rx_b, x_b;
    logic [5:0]  ry_b, y_b;
    logic [7:0]  fc_b;
    logic        ra_c, hs_c, vs_c, ia_c, ls_c, fs_c;
    logic [2:0]  rx_c, ry_c, x_c, y_c;
    logic [1:0]  fc_c;

    vga_timing_gen u_dut_a (
        .clock25Mhz (clk), .reset (rst_a), .reqActive (ra_a), .reqX (rx_a), .reqY (ry_a),
        .hSync (hs_a), .vSync (vs_a), .isActive (ia_a), .x (x_a), .y (y_a),
        .lineStart (ls_a), .frameStart (fs_a), .frameCount (fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .H_POL (1'b1), .V_POL (1'b1), .LEAD (1), .X_W (7), .Y_W (6), .FC_W (8)
    ) u_dut_b (
        .clock25Mhz (clk), .reset (rst_b), .reqActive (ra_b), .reqX (rx_b), .reqY (ry_b),
        .hSync (hs_b), .vSync (vs_b), .isActive (ia_b), .x (x_b), .y (y_b),
        .lineStart (ls_b), .frameStart (fs_b), .frameCount (fc_b)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .LEAD (2), .X_W (3), .Y_W (3), .FC_W (2)
    ) u_dut_c (
        .clock25Mhz (clk), .reset (rst_c), .reqActive (ra_c), .reqX (rx_c), .reqY (ry_c),
        .hSync (hs_c), .vSync (vs_c), .isActive (ia_c), .x (x_c), .y (y_c),
        .lineStart (ls_c), .frameStart (fs_c), .frameCount (fc_c)
    );

    // Request bundle for the n-th cycle since the last reset, from raster position alone.
    function automatic bnd_t req_at(input cfg_t c, input int n);
        bnd_t r;
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        int h  = n % ht;
        int v  = (n / ht) % vt;
        r.act = (h < c.ha && v < c.va) ? 1 : 0;
        r.x   = r.act ? h : 0;
        r.y   = r.act ? v : 0;
        r.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol : 1 - c.hpol;
        r.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol : 1 - c.vpol;
        r.ls  = (h == 0) ? 1 : 0;
        r.fs  = (h == 0 && v == 0) ? 1 : 0;
        return r;
    endfunction

    function automatic bnd_t disp_at(input cfg_t c, input int n);
        bnd_t r;
        if (n < c.lead) begin
            r = '{0, 0, 0, 1 - c.hpol, 1 - c.vpol, 0, 0};
        end else begin
            r = req_at(c, n - c.lead);
        end
        return r;
    endfunction

    function automatic int fc_at(input cfg_t c, input int n);
        int frame = (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
        return (n / frame) % (1 << c.fcw);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input cfg_t c, input int n,
                            input logic [31:0] ra, input logic [31:0] rx, input logic [31:0] ry,
                            input logic [31:0] hs, input logic [31:0] vs, input logic [31:0] ia,
                            input logic [31:0] x, input logic [31:0] y, input logic [31:0] ls,
                            input logic [31:0] fs, input logic [31:0] fc);
        bnd_t r = req_at(c, n);
        bnd_t d = disp_at(c, n);
        chk($sformatf("%s.reqActive@%0d", nm, n), ra, r.act);
        chk($sformatf("%s.reqX@%0d", nm, n), rx, r.x);
        chk($sformatf("%s.reqY@%0d", nm, n), ry, r.y);
        chk($sformatf("%s.hSync@%0d", nm, n), hs, d.hs);
        chk($sformatf("%s.vSync@%0d", nm, n), vs, d.vs);
        chk($sformatf("%s.isActive@%0d", nm, n), ia, d.act);
        chk($sformatf("%s.x@%0d", nm, n), x, d.x);
        chk($sformatf("%s.y@%0d", nm, n), y, d.y);
        chk($sformatf("%s.lineStart@%0d", nm, n), ls, d.ls);
        chk($sformatf("%s.frameStart@%0d", nm, n), fs, d.fs);
        chk($sformatf("%s.frameCount@%0d", nm, n), fc, fc_at(c, n));
    endtask

    // Cycle index since the last reset edge; a reset edge lands the design at index 0.
    always @(posedge clk) begin
        n_a     <= rst_a ? 0 : n_a + 1;
        n_b     <= rst_b ? 0 : n_b + 1;
        n_c     <= rst_c ? 0 : n_c + 1;
        valid_a <= valid_a | rst_a;
        valid_b <= valid_b | rst_b;
        valid_c <= valid_c | rst_c;
    end

    always @(negedge clk) begin
        if (valid_a) begin
            chk_inst("A", CfgA, n_a, 32'(ra_a), 32'(rx_a), 32'(ry_a), 32'(hs_a), 32'(vs_a),
                     32'(ia_a), 32'(x_a), 32'(y_a), 32'(ls_a), 32'(fs_a), 32'(fc_a));
            if (n_a == 0 && rst_a) begin
                chk("A.rst_hSync", 32'(hs_a), 1);
                chk("A.rst_vSync", 32'(vs_a), 1);
                chk("A.rst_isActive", 32'(ia_a), 0);
                chk("A.rst_frameCount", 32'(fc_a), 0);
            end
            if (n_a == 2) chk("A.frameStart@2", 32'(fs_a), 1);
            if (n_a == 641) chk("A.x@641", 32'(x_a), 639);
            if (n_a == 657) chk("A.hSync@657", 32'(hs_a), 1);
            if (n_a == 658) chk("A.hSync@658", 32'(hs_a), 0);
            if (n_a == 753) chk("A.hSync@753", 32'(hs_a), 0);
            if (n_a == 754) chk("A.hSync@754", 32'(hs_a), 1);
            if (n_a == 802) chk("A.y@802", 32'(y_a), 1);
        end
        if (valid_b) begin
            chk_inst("B", CfgB, n_b, 32'(ra_b), 32'(rx_b), 32'(ry_b), 32'(hs_b), 32'(vs_b),
                     32'(ia_b), 32'(x_b), 32'(y_b), 32'(ls_b), 32'(fs_b), 32'(fc_b));
            if (n_b == 0) chk("B.rst_hSync", 32'(hs_b), 0);
            if (n_b == 0) chk("B.rst_vSync", 32'(vs_b), 0);
            if (n_b == 1) chk("B.frameStart@1", 32'(fs_b), 1);
            if (n_b == 4401) chk("B.frameStart@4401", 32'(fs_b), 1);
            if (n_b == 4400) chk("B.frameCount@4400", 32'(fc_b), 1);
        end
        if (valid_c) begin
            chk_inst("C", CfgC, n_c, 32'(ra_c), 32'(rx_c), 32'(ry_c), 32'(hs_c), 32'(vs_c),
                     32'(ia_c), 32'(x_c), 32'(y_c), 32'(ls_c), 32'(fs_c), 32'(fc_c));
            if (n_c == 9) chk("C.lineStart@9", 32'(ls_c), 1);
            if (n_c == 35) chk("C.frameCount@35", 32'(fc_c), 1);
            if (n_c == 70) chk("C.frameCount@70", 32'(fc_c), 2);
            if (n_c == 105) chk("C.frameCount@105", 32'(fc_c), 3);
            if (n_c == 140) chk("C.frameCount@140", 32'(fc_c), 0);
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        // Mid-line reset on A at hc=300, vc=3.
        repeat (2700) @(posedge clk);
        #1 rst_a = 1'b1;
        @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (4000) @(posedge clk);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            rst_a = ($urandom_range(0, 1499) == 0);
            rst_b = ($urandom_range(0, 2999) == 0);
            rst_c = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1 rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
